fixed_to_float: RTL and testbench

FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

---
 rtl/fixed_to_float_if.sv | 33 +++
 rtl/fixed_to_float.sv | 106 ++++++++++
 tb/tb_fixed_to_float.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fixed_to_float_if.sv
// fixed_to_float_if
//   Request/response bundle between a requester and the fixed_to_float
//   converter.
//   start      : request strobe from the requester
//   fixedPoint : unsigned INTS.FRACS operand, WIDTH bits
//   result     : IEEE-754 single-precision result from the converter
//   done       : one-cycle pulse, result valid
//   busy       : converter is not idle
interface fixed_to_float_if #(
  parameter int WIDTH = 23
);
  logic             start;
  logic [WIDTH-1:0] fixedPoint;
  logic [31:0]      result;
  logic             done;
  logic             busy;

  modport master (
    output start,
    output fixedPoint,
    input  result,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  fixedPoint,
    output result,
    output done,
    output busy
  );
endinterface

// File: rtl/fixed_to_float.sv
// fixed_to_float
//   Converts an unsigned INTS.FRACS fixed-point magnitude into an IEEE-754
//   single-precision value by shifting left one bit per cycle until the
//   leading one reaches the top of the operand register. No rounding: low
//   bits that do not fit in the 23-bit fraction are dropped.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset, overrides clk_en
//   clk_en : while low every register holds
//   bus    : slave side of fixed_to_float_if (start, fixedPoint in;
//            result, done, busy out)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; captures operand and initial exponent
//   NORM  | shifting mantissa left until its MSB is set
//   DONE  | result register holds the new value, done pulses, back to IDLE
module fixed_to_float #(
  parameter int FRACS = 22,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  fixed_to_float_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exponent of the top operand bit: weight 2^(INTS-1), biased by 127.
  localparam logic [7:0] EXP_INIT = 8'(127 + INTS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mant_r, mant_nxt;
  logic [7:0]       exp_r, exp_nxt;
  logic [31:0]      result_r, result_nxt;

  // Place the normalized mantissa's hidden one at bit 23 so bits 22:0 are
  // the left-aligned fraction with zero fill below.
  function automatic logic [31:0] pack(input logic [WIDTH-1:0] mant,
                                       input logic [7:0]       expo);
    logic [23:0] aligned;
    aligned = 24'(mant) << (24 - WIDTH);
    return {1'b0, expo, aligned[22:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mant_r   <= '0;
      exp_r    <= '0;
      result_r <= '0;
    end else if (clk_en) begin
      state    <= state_nxt;
      mant_r   <= mant_nxt;
      exp_r    <= exp_nxt;
      result_r <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mant_nxt   = mant_r;
    exp_nxt    = exp_r;
    result_nxt = result_r;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          mant_nxt = bus.fixedPoint;
          exp_nxt  = EXP_INIT;
          if (bus.fixedPoint == '0) begin
            // Zero has no leading one to find; report +0.0 directly.
            result_nxt = 32'h0000_0000;
            state_nxt  = DONE;
          end else begin
            state_nxt = NORM;
          end
        end
      end
      NORM: begin
        if (mant_r[WIDTH-1]) begin
          result_nxt = pack(mant_r, exp_r);
          state_nxt  = DONE;
        end else begin
          mant_nxt = mant_r << 1;
          exp_nxt  = exp_r - 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.done   = (state == DONE);
  assign bus.busy   = (state != IDLE);
  assign bus.result = result_r;

endmodule

// File: tb/tb_fixed_to_float.sv
module tb_fixed_to_float;

  localparam int W = 23;

  typedef struct {
    logic [W-1:0] fp;
    logic [31:0]  res;
    int           lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  fixed_to_float_if #(.WIDTH(W)) bus ();

  fixed_to_float #(.FRACS(22), .INTS(1), .WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard monitor: every done pulse must match the oldest expectation
  // in both value and arrival cycle.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done cycle=%0d result=%h", cyc, bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (bus.result !== e.res) begin
          bad++;
          $display("FAIL %s result got=%h want=%h", e.name, bus.result, e.res);
        end
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL %s done_cycle got=%0d want=%0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic start_op(input string name, input logic [W-1:0] fp,
                          input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res; e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.fixedPoint = fp;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d want=0", name, sb.size());
      sb.delete();
    end
    tick();
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int a;
    vecs[0] = '{23'h400000, 32'h3F800000, 2};
    vecs[1] = '{23'h600000, 32'h3FC00000, 2};
    vecs[2] = '{23'h200000, 32'h3F000000, 3};
    vecs[3] = '{23'h000001, 32'h34800000, 24};
    vecs[4] = '{23'h000000, 32'h00000000, 1};
    vecs[5] = '{23'h7FFFFF, 32'h3FFFFFFE, 2};
    vecs[6] = '{23'h000100, 32'h38800000, 16};
    vecs[7] = '{23'h0ABCDE, 32'h3E2BCDE0, 5};

    rst_n = 1'b0;
    clk_en = 1'b0;
    bus.start = 1'b0;
    bus.fixedPoint = '0;
    repeat (3) tick();
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'h0);
    rst_n = 1'b1;
    clk_en = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      start_op($sformatf("vec%0d", i), vecs[i].fp, vecs[i].res, vecs[i].lat);
      drain($sformatf("vec%0d", i), 40);
    end

    // busy window for the slowest operand
    n = cyc;
    start_op("busy_win", 23'h000001, 32'h34800000, 24);
    for (int j = 1; j <= 24; j++) begin
      check($sformatf("busy_t%0d", j), {31'b0, bus.busy}, 32'd1);
      tick();
    end
    check("busy_after", {31'b0, bus.busy}, 32'd0);
    drain("busy_win", 5);

    // start while clk_en low in IDLE must not be taken
    clk_en = 1'b0;
    bus.start = 1'b1;
    bus.fixedPoint = 23'h400000;
    repeat (2) tick();
    check("frozen_idle_busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    clk_en = 1'b1;
    repeat (3) tick();

    // stall in NORM, operand change and start pulse while busy
    start_op("stall", 23'h100000, 32'h3E800000, 7);
    clk_en = 1'b0;
    bus.start = 1'b1;
    bus.fixedPoint = 23'h7FFFFF;
    repeat (3) tick();
    clk_en = 1'b1;
    tick();
    bus.start = 1'b0;
    drain("stall", 10);
    repeat (4) tick();

    // reset mid-operation, then start in the first cycle out of reset
    n = cyc;
    bus.start = 1'b1;
    bus.fixedPoint = 23'h000001;
    tick();
    bus.start = 1'b0;
    while (cyc < n + 5) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_result", bus.result, 32'h0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    rst_n = 1'b1;
    start_op("after_reset", 23'h400000, 32'h3F800000, 2);
    drain("after_reset", 5);

    // back-to-back with start held high
    a = cyc;
    bus.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      int l;
      l = (i % 2 == 0) ? 2 : 3;
      bus.fixedPoint = (i % 2 == 0) ? 23'h400000 : 23'h200000;
      e.res = (i % 2 == 0) ? 32'h3F800000 : 32'h3F000000;
      e.cyc = a + l;
      e.name = $sformatf("b2b%0d", i);
      sb.push_back(e);
      repeat (l + 1) tick();
      a = a + l + 1;
    end
    bus.start = 1'b0;
    drain("b2b", 10);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
